// File: rtl/leve1_pkg.sv
// rtl/leve1_pkg.sv - shared types, opcodes and helpers for the leve1 decode stage
package leve1_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        UNIT_ALU,
        UNIT_BRU,
        UNIT_JUMP,
        UNIT_LSU,
        UNIT_CSR,
        UNIT_FENCE
    } unit_e;

    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_LUI, OP_AUIPC,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD,
        OP_FENCE, OP_FENCE_I,
        OP_ECALL, OP_EBREAK, OP_MRET, OP_WFI,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
    } op_e;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_en;
        logic [XLEN-1:0] imm;
        unit_e           unit;
        op_e             op;
        logic            w32;
        logic            illegal;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    // Handshake occupancy: EMPTY (no entry), ONE (out reg), FULL (out reg + skid).
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } hs_state_e;

    function automatic op_e alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? OP_SUB : OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return alt ? OP_SRA : OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/leve1_dec.sv
// rtl/leve1_dec.sv - combinational RV64I instruction to control-bundle decoder
module leve1_dec
    import leve1_pkg::*;
(
    input  logic [31:0]      instr_i,
    output logic [DEC_W-1:0] dec_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    logic            use_rs1, use_rs2, use_rd, keep_rs1_field, ill, w32;
    logic [XLEN-1:0] imm;
    unit_e           unit;
    op_e             op;
    dec_t            dec;

    always_comb begin
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        use_rd         = 1'b0;
        keep_rs1_field = 1'b0;
        ill            = 1'b0;
        w32            = 1'b0;
        imm            = '0;
        unit           = UNIT_ALU;
        op             = OP_ADD;
        case (opcode)
            OPC_LUI: begin
                use_rd = 1'b1; imm = imm_u; op = OP_LUI;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1; imm = imm_u; op = OP_AUIPC;
            end
            OPC_JAL: begin
                use_rd = 1'b1; imm = imm_j; unit = UNIT_JUMP; op = OP_JAL;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i; unit = UNIT_JUMP; op = OP_JALR;
                ill = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b; unit = UNIT_BRU;
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i; unit = UNIT_LSU;
                case (funct3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b011:  op = OP_LD;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    3'b110:  op = OP_LWU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s; unit = UNIT_LSU;
                case (funct3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    3'b011:  op = OP_SD;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i;
                op = alu_op(funct3, (funct3 == 3'b101) && instr_i[30]);
                // RV64 shifts use a 6-bit shamt, so only instr[31:26] is the funct field.
                if (funct3 == 3'b001)
                    ill = (instr_i[31:26] != 6'b000000);
                else if (funct3 == 3'b101)
                    ill = (instr_i[31:26] != 6'b000000) && (instr_i[31:26] != 6'b010000);
            end
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                op = alu_op(funct3, instr_i[30]);
                ill = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OP_IMM_32: begin
                use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i; w32 = 1'b1;
                case (funct3)
                    3'b000:  op = OP_ADD;
                    3'b001:  begin op = OP_SLL; ill = (funct7 != 7'b0000000); end
                    3'b101:  begin
                        op  = instr_i[30] ? OP_SRA : OP_SRL;
                        ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; w32 = 1'b1;
                op = alu_op(funct3, instr_i[30]);
                case (funct3)
                    3'b000, 3'b101: ill = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    3'b001:         ill = (funct7 != 7'b0000000);
                    default:        ill = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin
                imm = imm_i; unit = UNIT_FENCE;
                case (funct3)
                    3'b000:  op = OP_FENCE;
                    3'b001:  op = OP_FENCE_I;
                    default: ill = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                unit = UNIT_CSR; imm = imm_i;
                case (funct3)
                    3'b000: begin
                        case (instr_i)
                            32'h0000_0073: op = OP_ECALL;
                            32'h0010_0073: op = OP_EBREAK;
                            32'h3020_0073: op = OP_MRET;
                            32'h1050_0073: op = OP_WFI;
                            default:       ill = 1'b1;
                        endcase
                    end
                    3'b001:  begin use_rs1 = 1'b1; use_rd = 1'b1; op = OP_CSRRW; end
                    3'b010:  begin use_rs1 = 1'b1; use_rd = 1'b1; op = OP_CSRRS; end
                    3'b011:  begin use_rs1 = 1'b1; use_rd = 1'b1; op = OP_CSRRC; end
                    // Immediate CSR forms: the rs1 field carries the 5-bit zimm, no register read.
                    3'b101:  begin keep_rs1_field = 1'b1; use_rd = 1'b1; op = OP_CSRRWI; end
                    3'b110:  begin keep_rs1_field = 1'b1; use_rd = 1'b1; op = OP_CSRRSI; end
                    3'b111:  begin keep_rs1_field = 1'b1; use_rd = 1'b1; op = OP_CSRRCI; end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        if (instr_i[1:0] != 2'b11)
            ill = 1'b1;

        dec = '0;
        if (ill) begin
            dec.illegal = 1'b1;
        end else begin
            dec.rs1    = (use_rs1 || keep_rs1_field) ? instr_i[19:15] : 5'd0;
            dec.rs2    = use_rs2 ? instr_i[24:20] : 5'd0;
            dec.rd     = use_rd  ? instr_i[11:7]  : 5'd0;
            dec.rs1_en = use_rs1;
            dec.rs2_en = use_rs2;
            dec.rd_en  = use_rd && (instr_i[11:7] != 5'd0);
            dec.imm    = imm;
            dec.unit   = unit;
            dec.op     = op;
            dec.w32    = w32;
        end
    end

    assign dec_o = dec;

endmodule

// File: rtl/leve1_id.sv
// rtl/leve1_id.sv - RV64I decode stage: registered output with one-entry skid buffer
module leve1_id #(
    parameter int              XLEN     = leve1_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       FLUSH,
    input  logic                       IVALID,
    output logic                       IREADY,
    input  logic [XLEN-1:0]            IPC,
    input  logic [31:0]                IINSTR,
    output logic                       OVALID,
    input  logic                       OREADY,
    output logic [XLEN-1:0]            OPC,
    output logic [leve1_pkg::DEC_W-1:0] ODEC
);

    localparam int DW = leve1_pkg::DEC_W;

    logic [DW-1:0] in_dec;

    leve1_dec u_dec (
        .instr_i (IINSTR),
        .dec_o   (in_dec)
    );

    leve1_pkg::hs_state_e state_q;
    logic                 ovalid_q, iready_q;
    logic [XLEN-1:0]      opc_q, skid_pc_q;
    logic [DW-1:0]        odec_q, skid_dec_q;
    logic                 accept;

    // An entry presented during FLUSH belongs to the squashed path and is never taken.
    assign accept = IVALID && iready_q && !FLUSH;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= leve1_pkg::ST_EMPTY;
            ovalid_q   <= 1'b0;
            iready_q   <= 1'b1;
            opc_q      <= RESET_PC;
            odec_q     <= '0;
            skid_pc_q  <= '0;
            skid_dec_q <= '0;
        end else if (FLUSH) begin
            state_q  <= leve1_pkg::ST_EMPTY;
            ovalid_q <= 1'b0;
            iready_q <= 1'b1;
            opc_q    <= RESET_PC;
            odec_q   <= '0;
        end else begin
            case (state_q)
                leve1_pkg::ST_EMPTY: begin
                    if (accept) begin
                        opc_q    <= IPC;
                        odec_q   <= in_dec;
                        ovalid_q <= 1'b1;
                        state_q  <= leve1_pkg::ST_ONE;
                    end
                end
                leve1_pkg::ST_ONE: begin
                    if (OREADY) begin
                        if (accept) begin
                            opc_q  <= IPC;
                            odec_q <= in_dec;
                        end else begin
                            opc_q    <= RESET_PC;
                            odec_q   <= '0;
                            ovalid_q <= 1'b0;
                            state_q  <= leve1_pkg::ST_EMPTY;
                        end
                    end else if (accept) begin
                        skid_pc_q  <= IPC;
                        skid_dec_q <= in_dec;
                        iready_q   <= 1'b0;
                        state_q    <= leve1_pkg::ST_FULL;
                    end
                end
                leve1_pkg::ST_FULL: begin
                    if (OREADY) begin
                        opc_q    <= skid_pc_q;
                        odec_q   <= skid_dec_q;
                        iready_q <= 1'b1;
                        state_q  <= leve1_pkg::ST_ONE;
                    end
                end
                default: begin
                    state_q  <= leve1_pkg::ST_EMPTY;
                    ovalid_q <= 1'b0;
                    iready_q <= 1'b1;
                end
            endcase
        end
    end

    assign IREADY = iready_q;
    assign OVALID = ovalid_q;
    assign OPC    = opc_q;
    assign ODEC   = odec_q;

endmodule
